// File: rtl/huffman_tree_builder.sv
// Iterative Huffman tree builder: repeatedly merges the two lightest active
// nodes of a 2*NSYM-1 entry node table using a single scan/merge FSM.
module huffman_tree_builder #(
    parameter int NSYM = 8,
    parameter int WW   = 8,
    parameter int SW   = WW + $clog2(NSYM),
    parameter int IW   = $clog2(2*NSYM-1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [IW-1:0] rd_addr,
    output logic [SW-1:0] rd_weight,
    output logic [IW-1:0] rd_left,
    output logic [IW-1:0] rd_right,
    output logic [IW-1:0] rd_parent,
    output logic          rd_branch
);
    localparam int NN = 2*NSYM - 1;

    typedef enum logic [1:0] {IDLE, SCAN, MERGE, DONE} state_t;

    state_t        state_reg;
    logic [IW-1:0] m_reg;
    logic [IW-1:0] p_reg;
    logic [IW-1:0] min1_idx_reg, min2_idx_reg;
    logic [SW-1:0] min1_w_reg, min2_w_reg;
    logic          min1_vld_reg, min2_vld_reg;
    logic          busy_reg, done_reg;

    logic [SW-1:0] weight_w [NN];
    logic [IW-1:0] left_w   [NN];
    logic [IW-1:0] right_w  [NN];
    logic [IW-1:0] parent_w [NN];
    logic          branch_w [NN];
    logic          active_w [NN];

    logic [IW-1:0] k_w;
    logic [SW-1:0] sum_w;
    logic [SW-1:0] scan_w;
    logic          scan_act;

    assign k_w      = IW'(NSYM) + m_reg;
    assign sum_w    = min1_w_reg + min2_w_reg;
    assign scan_w   = weight_w[p_reg];
    assign scan_act = active_w[p_reg];

    // Each table entry owns its registers so the merge can update the new
    // node and both children in the same cycle.
    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_node
            localparam bit IS_LEAF = (gi < NSYM);
            logic [SW-1:0] weight_reg;
            logic [IW-1:0] left_reg, right_reg, parent_reg;
            logic          branch_reg, active_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    weight_reg <= '0;
                    left_reg   <= '0;
                    right_reg  <= '0;
                    parent_reg <= '0;
                    branch_reg <= 1'b0;
                    active_reg <= 1'b0;
                end else if (state_reg == IDLE) begin
                    if (start) begin
                        parent_reg <= '0;
                        branch_reg <= 1'b0;
                        if (IS_LEAF) begin
                            active_reg <= 1'b1;
                        end else begin
                            weight_reg <= '0;
                            left_reg   <= '0;
                            right_reg  <= '0;
                            active_reg <= 1'b0;
                        end
                    end
                    if (IS_LEAF && wr_en && wr_addr == IW'(gi)) begin
                        weight_reg <= SW'(wr_data);
                        active_reg <= 1'b1;
                    end
                end else if (state_reg == MERGE) begin
                    if (k_w == IW'(gi)) begin
                        weight_reg <= sum_w;
                        left_reg   <= min1_idx_reg;
                        right_reg  <= min2_idx_reg;
                        active_reg <= 1'b1;
                    end
                    if (min1_idx_reg == IW'(gi)) begin
                        active_reg <= 1'b0;
                        parent_reg <= k_w;
                        branch_reg <= 1'b0;
                    end
                    if (min2_idx_reg == IW'(gi)) begin
                        active_reg <= 1'b0;
                        parent_reg <= k_w;
                        branch_reg <= 1'b1;
                    end
                end
            end

            assign weight_w[gi] = weight_reg;
            assign left_w[gi]   = left_reg;
            assign right_w[gi]  = right_reg;
            assign parent_w[gi] = parent_reg;
            assign branch_w[gi] = branch_reg;
            assign active_w[gi] = active_reg;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            m_reg        <= '0;
            p_reg        <= '0;
            min1_idx_reg <= '0;
            min2_idx_reg <= '0;
            min1_w_reg   <= '0;
            min2_w_reg   <= '0;
            min1_vld_reg <= 1'b0;
            min2_vld_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= SCAN;
                        busy_reg     <= 1'b1;
                        m_reg        <= '0;
                        p_reg        <= '0;
                        min1_vld_reg <= 1'b0;
                        min2_vld_reg <= 1'b0;
                    end
                end
                SCAN: begin
                    // Strict compares keep the lower index on equal weights.
                    if (scan_act) begin
                        if (!min1_vld_reg || scan_w < min1_w_reg) begin
                            min2_idx_reg <= min1_idx_reg;
                            min2_w_reg   <= min1_w_reg;
                            min2_vld_reg <= min1_vld_reg;
                            min1_idx_reg <= p_reg;
                            min1_w_reg   <= scan_w;
                            min1_vld_reg <= 1'b1;
                        end else if (!min2_vld_reg || scan_w < min2_w_reg) begin
                            min2_idx_reg <= p_reg;
                            min2_w_reg   <= scan_w;
                            min2_vld_reg <= 1'b1;
                        end
                    end
                    if (p_reg == k_w - IW'(1)) begin
                        state_reg <= MERGE;
                    end else begin
                        p_reg <= p_reg + IW'(1);
                    end
                end
                MERGE: begin
                    if (m_reg == IW'(NSYM-2)) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                    end else begin
                        m_reg        <= m_reg + IW'(1);
                        p_reg        <= '0;
                        min1_vld_reg <= 1'b0;
                        min2_vld_reg <= 1'b0;
                        state_reg    <= SCAN;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !(rd_addr < IW'(NN))) begin
            rd_weight <= '0;
            rd_left   <= '0;
            rd_right  <= '0;
            rd_parent <= '0;
            rd_branch <= 1'b0;
        end else begin
            rd_weight <= weight_w[rd_addr];
            rd_left   <= left_w[rd_addr];
            rd_right  <= right_w[rd_addr];
            rd_parent <= parent_w[rd_addr];
            rd_branch <= branch_w[rd_addr];
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_huffman_tree_builder.sv
// Directed bench for huffman_tree_builder: one NSYM=4 and one NSYM=8 instance
// sharing clock and reset, checked against hand-built trees.
module tb_huffman_tree_builder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // NSYM=4 instance: IW=3, SW=10
    logic       a_wr_en = 0, a_start = 0, a_busy, a_done, a_branch;
    logic [2:0] a_wr_addr = 0, a_rd_addr = 0, a_left, a_right, a_parent;
    logic [7:0] a_wr_data = 0;
    logic [9:0] a_weight;

    // NSYM=8 instance: IW=4, SW=11
    logic        b_wr_en = 0, b_start = 0, b_busy, b_done, b_branch;
    logic [3:0]  b_wr_addr = 0, b_rd_addr = 0, b_left, b_right, b_parent;
    logic [7:0]  b_wr_data = 0;
    logic [10:0] b_weight;

    huffman_tree_builder #(.NSYM(4), .WW(8)) u4 (
        .CLK(clk), .RST(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .start(a_start), .busy(a_busy), .done(a_done), .rd_addr(a_rd_addr),
        .rd_weight(a_weight), .rd_left(a_left), .rd_right(a_right),
        .rd_parent(a_parent), .rd_branch(a_branch));

    huffman_tree_builder #(.NSYM(8), .WW(8)) u8 (
        .CLK(clk), .RST(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .start(b_start), .busy(b_busy), .done(b_done), .rd_addr(b_rd_addr),
        .rd_weight(b_weight), .rd_left(b_left), .rd_right(b_right),
        .rd_parent(b_parent), .rd_branch(b_branch));

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic a_load(input int w0, input int w1, input int w2, input int w3);
        int w[4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            a_wr_en = 1; a_wr_addr = 3'(i); a_wr_data = 8'(w[i]);
            @(posedge clk); #1;
            a_wr_en = 0;
        end
    endtask

    task automatic a_read(input int idx);
        a_rd_addr = 3'(idx);
        @(posedge clk); #1;
    endtask

    task automatic b_read(input int idx);
        b_rd_addr = 4'(idx);
        @(posedge clk); #1;
    endtask

    // Start a build and return the cycle count from the start edge to done
    // (0 if done never arrives). poke_at>0 injects start+write during the build.
    task automatic a_run(input int poke_at, input logic co_wr, input logic [2:0] co_addr,
                         input logic [7:0] co_data, output int n);
        a_start = 1; a_wr_en = co_wr; a_wr_addr = co_addr; a_wr_data = co_data;
        @(posedge clk); #1;
        a_start = 0; a_wr_en = 0;
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c == poke_at) begin
                a_start = 1; a_wr_en = 1; a_wr_addr = 3'd0; a_wr_data = 8'd99;
            end
            @(posedge clk); #1;
            a_start = 0; a_wr_en = 0;
            if (a_done) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic b_load_run(input int base, input int step, output int n);
        for (int i = 0; i < 8; i++) begin
            b_wr_en = 1; b_wr_addr = 4'(i); b_wr_data = 8'(base + step*i);
            @(posedge clk); #1;
            b_wr_en = 0;
        end
        b_start = 1;
        @(posedge clk); #1;
        b_start = 0;
        n = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (b_done) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        n_cmp++;
        if ({a_busy, a_done, b_busy, b_done} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got busy/done a=%b%b b=%b%b want 0000", a_busy, a_done, b_busy, b_done);
        end
        n_cmp++;
        if ({a_weight, a_left, a_right, a_parent, a_branch} !== '0) begin
            n_bad++;
            $display("FAIL reset_rd: got w=%0d l=%0d r=%0d p=%0d b=%0d want all 0",
                     a_weight, a_left, a_right, a_parent, a_branch);
        end
        for (int i = 0; i < 7; i++) begin
            a_read(i);
            n_cmp++;
            if ({a_weight, a_left, a_right, a_parent, a_branch} !== '0) begin
                n_bad++;
                $display("FAIL reset_node%0d: got w=%0d l=%0d r=%0d p=%0d b=%0d want all 0",
                         i, a_weight, a_left, a_right, a_parent, a_branch);
            end
        end
        $display("reset: checked control and 7 table entries");
    endtask

    // Shared by test_basic and test_ignored: tree for weights 1,2,3,4.
    task automatic check_tree_1234(input string tag);
        int ew[7] = '{1, 2, 3, 4, 3, 6, 10};
        int el[7] = '{0, 0, 0, 0, 0, 2, 3};
        int er[7] = '{0, 0, 0, 0, 1, 4, 5};
        int ep[7] = '{4, 4, 5, 6, 5, 6, 0};
        int eb[7] = '{0, 1, 0, 0, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            a_read(i);
            n_cmp++;
            if (a_weight !== 10'(ew[i]) || a_left !== 3'(el[i]) || a_right !== 3'(er[i]) ||
                a_parent !== 3'(ep[i]) || a_branch !== 1'(eb[i])) begin
                n_bad++;
                $display("FAIL %s_node%0d: got w=%0d l=%0d r=%0d p=%0d b=%0d want w=%0d l=%0d r=%0d p=%0d b=%0d",
                         tag, i, a_weight, a_left, a_right, a_parent, a_branch,
                         ew[i], el[i], er[i], ep[i], eb[i]);
            end
        end
    endtask

    task automatic test_basic();
        int n;
        a_load(1, 2, 3, 4);
        a_run(0, 1'b0, 3'd0, 8'd0, n);
        n_cmp++;
        if (n !== 19) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d want 19", n);
        end
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_at_done: got %b want 0", a_busy);
        end
        check_tree_1234("basic");
        $display("basic: weights 1,2,3,4 latency=%0d", n);
    endtask

    task automatic test_ties();
        int n;
        int ew[7] = '{5, 5, 5, 5, 10, 10, 20};
        int el[7] = '{0, 0, 0, 0, 0, 2, 4};
        int er[7] = '{0, 0, 0, 0, 1, 3, 5};
        int ep[7] = '{4, 4, 5, 5, 6, 6, 0};
        int eb[7] = '{0, 1, 0, 1, 0, 1, 0};
        a_load(5, 5, 5, 5);
        a_run(0, 1'b0, 3'd0, 8'd0, n);
        n_cmp++;
        if (n !== 19) begin
            n_bad++;
            $display("FAIL ties_latency: got %0d want 19", n);
        end
        for (int i = 0; i < 7; i++) begin
            a_read(i);
            n_cmp++;
            if (a_weight !== 10'(ew[i]) || a_left !== 3'(el[i]) || a_right !== 3'(er[i]) ||
                a_parent !== 3'(ep[i]) || a_branch !== 1'(eb[i])) begin
                n_bad++;
                $display("FAIL ties_node%0d: got w=%0d l=%0d r=%0d p=%0d b=%0d want w=%0d l=%0d r=%0d p=%0d b=%0d",
                         i, a_weight, a_left, a_right, a_parent, a_branch,
                         ew[i], el[i], er[i], ep[i], eb[i]);
            end
        end
        $display("ties: all weights 5 latency=%0d", n);
    endtask

    task automatic test_wide();
        int n;
        b_load_run(255, 0, n);
        n_cmp++;
        if (n !== 85) begin
            n_bad++;
            $display("FAIL wide_latency: got %0d want 85", n);
        end
        b_read(14);
        n_cmp++;
        if (b_weight !== 11'd2040 || b_parent !== 4'd0) begin
            n_bad++;
            $display("FAIL wide_root: got w=%0d p=%0d want w=2040 p=0", b_weight, b_parent);
        end
        $display("wide: all weights 255 root=%0d latency=%0d", b_weight, n);
    endtask

    task automatic test_abort();
        int n;
        int seen;
        for (int i = 0; i < 8; i++) begin
            b_wr_en = 1; b_wr_addr = 4'(i); b_wr_data = 8'(i + 1);
            @(posedge clk); #1;
            b_wr_en = 0;
        end
        b_start = 1;
        @(posedge clk); #1;
        b_start = 0;
        repeat (29) @(posedge clk);
        #1;
        pulse_reset();
        n_cmp++;
        if (b_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_busy: got %b want 0", b_busy);
        end
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (b_done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_done: got %0d done pulses want 0", seen);
        end
        for (int i = 0; i < 15; i++) begin
            b_read(i);
            n_cmp++;
            if ({b_weight, b_left, b_right, b_parent, b_branch} !== '0) begin
                n_bad++;
                $display("FAIL abort_node%0d: got w=%0d l=%0d r=%0d p=%0d b=%0d want all 0",
                         i, b_weight, b_left, b_right, b_parent, b_branch);
            end
        end
        b_load_run(1, 1, n);
        n_cmp++;
        if (n !== 85) begin
            n_bad++;
            $display("FAIL abort_reload_latency: got %0d want 85", n);
        end
        b_read(14);
        n_cmp++;
        if (b_weight !== 11'd36) begin
            n_bad++;
            $display("FAIL abort_reload_root: got %0d want 36", b_weight);
        end
        $display("abort: reset mid-build, reload 1..8 root=%0d latency=%0d", b_weight, n);
    endtask

    task automatic test_ignored();
        int n;
        pulse_reset();
        a_load(1, 2, 3, 4);
        a_run(6, 1'b0, 3'd0, 8'd0, n);
        n_cmp++;
        if (n !== 19) begin
            n_bad++;
            $display("FAIL ignored_latency: got %0d want 19", n);
        end
        check_tree_1234("ignored");
        $display("ignored: start+write during build latency=%0d", n);
    endtask

    task automatic test_zero();
        int n;
        int ew[7] = '{0, 0, 7, 1, 0, 1, 8};
        int el[7] = '{0, 0, 0, 0, 0, 4, 5};
        int er[7] = '{0, 0, 0, 0, 1, 3, 2};
        int ep[7] = '{4, 4, 6, 5, 5, 6, 0};
        int eb[7] = '{0, 1, 1, 1, 0, 0, 0};
        pulse_reset();
        a_load(0, 0, 7, 9);
        a_wr_en = 1; a_wr_addr = 3'd5; a_wr_data = 8'd9;
        @(posedge clk); #1;
        a_wr_en = 0;
        a_read(5);
        n_cmp++;
        if (a_weight !== 10'd0) begin
            n_bad++;
            $display("FAIL zero_oob_write: got node5 w=%0d want 0", a_weight);
        end
        // Leaf 3 is rewritten to 1 in the same cycle as start.
        a_run(0, 1'b1, 3'd3, 8'd1, n);
        n_cmp++;
        if (n !== 19) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d want 19", n);
        end
        for (int i = 0; i < 7; i++) begin
            a_read(i);
            n_cmp++;
            if (a_weight !== 10'(ew[i]) || a_left !== 3'(el[i]) || a_right !== 3'(er[i]) ||
                a_parent !== 3'(ep[i]) || a_branch !== 1'(eb[i])) begin
                n_bad++;
                $display("FAIL zero_node%0d: got w=%0d l=%0d r=%0d p=%0d b=%0d want w=%0d l=%0d r=%0d p=%0d b=%0d",
                         i, a_weight, a_left, a_right, a_parent, a_branch,
                         ew[i], el[i], er[i], ep[i], eb[i]);
            end
        end
        $display("zero: weights 0,0,7,1 with ignored addr-5 write latency=%0d", n);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_wide();
        test_abort();
        test_ignored();
        test_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
